// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_WAIT = 2'd1,
    ST_DM_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_dm,
  input  gnt_e last_grant,
  output gnt_e grant
);

  always_comb begin
    grant = GNT_IF;
    if (req_if && req_dm) begin
      grant = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
    end else if (req_dm) begin
      grant = GNT_DM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-outstanding
// memory port, with a completion timeout and sticky error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state;
  state_e           state_nxt;
  gnt_e             last_grant;
  gnt_e             pick;
  logic [CNT_W-1:0] wait_cnt;
  logic             if_elig;
  logic             dm_elig;
  logic             issue;
  logic             complete;
  logic             expire;

  // A requester whose ready is high this cycle is masked to avoid re-issuing.
  assign if_elig = if_req && !if_ready;
  assign dm_elig = dm_req && !dm_ready;

  rr_pick2 u_pick (
    .req_if     (if_elig),
    .req_dm     (dm_elig),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    complete  = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_elig || dm_elig) begin
          issue     = 1'b1;
          state_nxt = (pick == GNT_DM) ? ST_DM_WAIT : ST_IF_WAIT;
        end
      end
      ST_IF_WAIT, ST_DM_WAIT: begin
        if (mem_valid) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, completion capture and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_IF;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_en   <= issue;
      if_ready <= complete && (state == ST_IF_WAIT);
      dm_ready <= complete && (state == ST_DM_WAIT);
      busy     <= (state_nxt != ST_IDLE);
      if (expire) begin
        err <= 1'b1;
      end
      if (issue) begin
        last_grant <= pick;
        wait_cnt   <= '0;
        if (pick == GNT_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end else if (state != ST_IDLE) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (complete && (state == ST_IF_WAIT)) begin
        if_rdata <= mem_rdata;
      end
      if (complete && (state == ST_DM_WAIT) && !mem_we) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 255;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;
  int n_en  = 0;
  int n_ifr = 0;
  int n_dmr = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=fetch 2=data; last 1=fetch 2=data.
  bit            m_on = 1'b0;
  int            m_owner, m_waited, m_last;
  bit            e_en, e_we, e_ifr, e_dmr, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ifd, e_dmd;

  always @(posedge clk) begin : model
    bit ifr_prev, dmr_prev, want_if, want_dm;
    int who;
    if (rst) begin
      m_on = 1'b1; m_owner = 0; m_waited = 0; m_last = 1;
      e_en = 0; e_we = 0; e_ifr = 0; e_dmr = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_ifd = '0; e_dmd = '0;
    end else if (m_on) begin
      ifr_prev = e_ifr;
      dmr_prev = e_dmr;
      e_en = 0; e_ifr = 0; e_dmr = 0;
      if (m_owner == 0) begin
        want_if = if_req && !ifr_prev;
        want_dm = dm_req && !dmr_prev;
        who = 0;
        if (want_if && want_dm) who = (m_last == 1) ? 2 : 1;
        else if (want_if)       who = 1;
        else if (want_dm)       who = 2;
        if (who != 0) begin
          m_owner = who; m_last = who; m_waited = 0; e_en = 1;
          if (who == 1) begin
            e_we = 0; e_addr = if_addr; e_wdata = '0;
          end else begin
            e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
          end
        end
      end else if (mem_valid) begin
        if (m_owner == 1) begin
          e_ifr = 1; e_ifd = mem_rdata;
        end else begin
          e_dmr = 1;
          if (!e_we) e_dmd = mem_rdata;
        end
        m_owner = 0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin
          m_owner = 0; e_err = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("mem_en",    32'(mem_en),    32'(e_en));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("if_ready",  32'(if_ready),  32'(e_ifr));
      chk("dm_ready",  32'(dm_ready),  32'(e_dmr));
      chk("if_rdata",  32'(if_rdata),  32'(e_ifd));
      chk("dm_rdata",  32'(dm_rdata),  32'(e_dmd));
      chk("busy",      32'(busy),      32'(m_owner != 0));
      chk("err",       32'(err),       32'(e_err));
      if (mem_en === 1'b1)   n_en++;
      if (if_ready === 1'b1) n_ifr++;
      if (dm_ready === 1'b1) n_dmr++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic give_valid(input logic [DW-1:0] d);
    mem_valid = 1'b1;
    mem_rdata = d;
    step(1);
    mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt;
    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_valid = 0;
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    // Lone fetch, memory answers 3 cycles after the issue strobe.
    if_req = 1; if_addr = 16'h0010;
    step(1);
    if_req = 0;
    chk("lf_en", 32'(mem_en), 32'd1);
    chk("lf_addr", 32'(mem_addr), 32'h0010);
    chk("lf_we", 32'(mem_we), 32'd0);
    step(3);
    give_valid(16'hA5A5);
    chk("lf_ready", 32'(if_ready), 32'd1);
    chk("lf_rdata", 32'(if_rdata), 32'hA5A5);
    step(2);
    chk("lf_en_cnt", 32'(n_en), 32'd1);
    chk("lf_rdy_cnt", 32'(n_ifr), 32'd1);

    // Tie after reset, both requests held across completions.
    do_reset();
    if_req = 1; if_addr = 16'h0020;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0300; dm_wdata = 16'h00FF;
    step(1);
    chk("tie1_addr", 32'(mem_addr), 32'h0300);
    give_valid(16'h0BEE);
    chk("tie1_dmr", 32'(dm_ready), 32'd1);
    chk("tie1_rdata", 32'(dm_rdata), 32'h0BEE);
    step(1);
    chk("tie2_en", 32'(mem_en), 32'd1);
    chk("tie2_addr", 32'(mem_addr), 32'h0020);
    chk("tie2_wdata", 32'(mem_wdata), 32'h0000);
    give_valid(16'h1111);
    chk("tie2_rdata", 32'(if_rdata), 32'h1111);
    if_req = 0; dm_req = 0;
    step(1);
    if_req = 1; dm_req = 1;
    step(1);
    chk("tie3_addr", 32'(mem_addr), 32'h0300);
    give_valid(16'h2222);
    if_req = 0; dm_req = 0;
    chk("tie3_rdata", 32'(dm_rdata), 32'h2222);
    step(1);

    // Store leaves dm_rdata untouched.
    dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    step(1);
    dm_req = 0;
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", 32'(mem_wdata), 32'h1234);
    step(1);
    give_valid(16'hDEAD);
    chk("st_ready", 32'(dm_ready), 32'd1);
    chk("st_rdata", 32'(dm_rdata), 32'h2222);
    step(1);

    // Stray mem_valid while idle.
    give_valid(16'h5555);
    chk("idle_ifr", 32'(if_ready), 32'd0);
    chk("idle_rdata", 32'(if_rdata), 32'h1111);
    step(1);

    // Timeout on a fetch, then a data read is still serviced.
    dm_we = 0;
    if_req = 1; if_addr = 16'h0040;
    step(1);
    if_req = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      step(1);
    end
    chk("to_cycles", 32'(cnt), 32'(TO));
    chk("to_err", 32'(err), 32'd1);
    chk("to_ifr_cnt", 32'(n_ifr), 32'd2);
    dm_req = 1; dm_addr = 16'h0050;
    step(1);
    dm_req = 0;
    chk("post_to_addr", 32'(mem_addr), 32'h0050);
    give_valid(16'h7777);
    chk("post_to_rdata", 32'(dm_rdata), 32'h7777);
    chk("err_sticky", 32'(err), 32'd1);
    step(1);

    // Reset during DM_WAIT, late mem_valid afterwards.
    dm_req = 1; dm_addr = 16'h0060;
    step(1);
    dm_req = 0;
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    give_valid(16'h9999);
    chk("rw_dmr", 32'(dm_ready), 32'd0);
    chk("rw_rdata", 32'(dm_rdata), 32'd0);
    chk("rw_err", 32'(err), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
